// File: rtl/mode_pkg.sv
// Shared constants and types for the mode-finder window buffer.
package mode_pkg;

  localparam int DATA_W   = 4;
  localparam int WIN_LEN  = 5;
  localparam int CNT_BITS = 3;

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIN_LEN - 1);

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic {
    ST_FILL,
    ST_FULL
  } win_state_e;

endpackage

// File: rtl/mode_win_buf_if.sv
// Sample-in / window-out handshake bundle between a producer, the window buffer and the mode finder.
interface mode_win_buf_if #(
  parameter int CNT_W = 8
);
  import mode_pkg::*;

  logic             in_valid;
  sample_t          in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  sample_t          i0;
  sample_t          i1;
  sample_t          i2;
  sample_t          i3;
  sample_t          i4;
  logic [CNT_W-1:0] win_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, i0, i1, i2, i3, i4, win_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, i0, i1, i2, i3, i4, win_cnt
  );

endinterface

// File: rtl/mode_win_ctrl.sv
// Fill counter and window-valid FSM; MODE_WIN_SLIDE_EN selects sliding instead of disjoint windows.
module mode_win_ctrl
  import mode_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic shift_en,
  output logic pop
);

  win_state_e          state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                ov_reg, ov_next;
  logic                acc;

  assign in_ready  = ~ov_reg | out_ready;
  assign out_valid = ov_reg;
  assign acc       = in_valid & in_ready;
  assign pop       = ov_reg & out_ready;
  // A flushed cycle must not disturb the stored window.
  assign shift_en  = acc & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FILL;
      cnt_reg   <= '0;
      ov_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ov_reg    <= ov_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ov_next    = ov_reg & ~pop;
    if (flush) begin
      state_next = ST_FILL;
      cnt_next   = '0;
      ov_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (acc) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
              ov_next    = 1'b1;
              state_next = ST_FULL;
            end
          end
        end
        ST_FULL: begin
`ifdef MODE_WIN_SLIDE_EN
          // Every new sample in a full window presents the shifted window.
          if (acc) ov_next = 1'b1;
`else
          if (pop) begin
            cnt_next   = acc ? CNT_BITS'(1) : '0;
            state_next = ST_FILL;
          end
`endif
        end
        default: begin
          state_next = ST_FILL;
          cnt_next   = '0;
          ov_next    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mode_win_buf.sv
// Five-sample window buffer feeding mode_max; MODE_WIN_SLIDE_EN selects sliding windows (default disjoint).
module mode_win_buf
  import mode_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  mode_win_buf_if.slave  bus
);

  sample_t          win_reg  [WIN_LEN];
  sample_t          win_next [WIN_LEN];
  logic [CNT_W-1:0] win_cnt_reg;
  logic             shift_en;
  logic             pop;
  logic             in_ready;
  logic             out_valid;

  mode_win_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .shift_en  (shift_en),
    .pop       (pop)
  );

  // Oldest sample sits at index 0; new samples enter at the top.
  genvar gi;
  generate
    for (gi = 0; gi < WIN_LEN; gi++) begin : g_shift
      if (gi == WIN_LEN - 1) begin : g_top
        assign win_next[gi] = bus.in_data;
      end else begin : g_mid
        assign win_next[gi] = win_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WIN_LEN; k++) win_reg[k] <= '0;
    end else if (shift_en) begin
      win_reg <= win_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      win_cnt_reg <= '0;
    else if (pop) win_cnt_reg <= win_cnt_reg + 1'b1;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.i0        = win_reg[0];
  assign bus.i1        = win_reg[1];
  assign bus.i2        = win_reg[2];
  assign bus.i3        = win_reg[3];
  assign bus.i4        = win_reg[4];
  assign bus.win_cnt   = win_cnt_reg;

endmodule

// File: tb/tb_mode_win_buf.sv
// Directed bench for mode_win_buf (CNT_W=2); expectations follow MODE_WIN_SLIDE_EN when defined.
module tb_mode_win_buf;
  import mode_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mode_win_buf_if #(.CNT_W(2)) bus ();

  mode_win_buf #(.CNT_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input sample_t d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_win(input string tag, input int a, input int b, input int c, input int d, input int e);
    check_eq({tag, "_i0"}, 32'(bus.i0), 32'(a));
    check_eq({tag, "_i1"}, 32'(bus.i1), 32'(b));
    check_eq({tag, "_i2"}, 32'(bus.i2), 32'(c));
    check_eq({tag, "_i3"}, 32'(bus.i3), 32'(d));
    check_eq({tag, "_i4"}, 32'(bus.i4), 32'(e));
    $display("window %s: %0d %0d %0d %0d %0d valid=%0d", tag, bus.i0, bus.i1, bus.i2, bus.i3, bus.i4, bus.out_valid);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int windows;
    int last_i0;
    int last_i4;
    logic [1:0] exp_cnt;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_win_cnt", 32'(bus.win_cnt), 0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 1);
    check_eq("rst_i4", 32'(bus.i4), 0);

    // Fill 3,7,7,1,9 then pop
    bus.out_ready = 1'b1;
    feed(4'd3); feed(4'd7); feed(4'd7); feed(4'd1);
    check_eq("fill_not_yet", 32'(bus.out_valid), 0);
    feed(4'd9);
    check_eq("fill_valid", 32'(bus.out_valid), 1);
    check_win("fill", 3, 7, 7, 1, 9);
    step();
    check_eq("fill_pop_cnt", 32'(bus.win_cnt), 1);
    check_eq("fill_pop_valid", 32'(bus.out_valid), 0);

    // Backpressure with a pending sample
    do_reset();
    feed(4'd1); feed(4'd2); feed(4'd3); feed(4'd4); feed(4'd5);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd6;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("bp_in_ready", 32'(bus.in_ready), 0);
      step();
      check_eq("bp_valid", 32'(bus.out_valid), 1);
      check_eq("bp_i0", 32'(bus.i0), 1);
      check_eq("bp_i4", 32'(bus.i4), 5);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("bp_pop_cnt", 32'(bus.win_cnt), 1);
`ifdef MODE_WIN_SLIDE_EN
    check_eq("slide_valid", 32'(bus.out_valid), 1);
    check_win("slide", 2, 3, 4, 5, 6);
`else
    check_eq("disj_valid_clear", 32'(bus.out_valid), 0);
    check_eq("disj_i4_kept", 32'(bus.i4), 6);
    feed(4'd7); feed(4'd8); feed(4'd9);
    check_eq("disj_not_yet", 32'(bus.out_valid), 0);
    feed(4'd10);
    check_eq("disj_valid", 32'(bus.out_valid), 1);
    check_win("disj", 6, 7, 8, 9, 10);
`endif

    // Stream 0..9 with out_ready held high
    do_reset();
    bus.out_ready = 1'b1;
    windows = 0;
    last_i0 = -1;
    last_i4 = -1;
    for (int k = 0; k < 10; k++) begin
      feed(sample_t'(k));
      if (bus.out_valid) begin
        windows++;
        if (windows == 1) check_win("stream_first", 0, 1, 2, 3, 4);
        last_i0 = int'(bus.i0);
        last_i4 = int'(bus.i4);
      end
    end
    step();
    check_eq("stream_drained", 32'(bus.out_valid), 0);
    step();
    check_eq("stream_idle", 32'(bus.out_valid), 0);
`ifdef MODE_WIN_SLIDE_EN
    check_eq("stream_windows", 32'(windows), 6);
`else
    check_eq("stream_windows", 32'(windows), 2);
`endif
    check_eq("stream_last_i0", 32'(last_i0), 5);
    check_eq("stream_last_i4", 32'(last_i4), 9);
    check_eq("stream_win_cnt", 32'(bus.win_cnt), 2);

    // Flush after 3 samples, same-cycle accept discarded
    do_reset();
    feed(4'd10); feed(4'd11); feed(4'd12);
    flush = 1'b1;
    feed(4'd13);
    flush = 1'b0;
    check_eq("flush_valid", 32'(bus.out_valid), 0);
    check_eq("flush_i4_kept", 32'(bus.i4), 12);
    feed(4'hA); feed(4'hB); feed(4'hC); feed(4'hD);
    check_eq("flush_refill_partial", 32'(bus.out_valid), 0);
    feed(4'hE);
    check_eq("flush_refill_valid", 32'(bus.out_valid), 1);
    check_win("flush", 10, 11, 12, 13, 14);
    // Flush with a simultaneous pop still counts the window
    flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("flush_pop_valid", 32'(bus.out_valid), 0);
    check_eq("flush_pop_cnt", 32'(bus.win_cnt), 1);
    check_eq("flush_pop_i4", 32'(bus.i4), 14);

    // Reset while a window is pending
    feed(4'd1); feed(4'd2); feed(4'd3); feed(4'd4); feed(4'd5);
    check_eq("rst_mid_pre_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_valid", 32'(bus.out_valid), 0);
    check_eq("rst_mid_win_cnt", 32'(bus.win_cnt), 0);
    check_eq("rst_mid_i4", 32'(bus.i4), 0);
    check_eq("rst_mid_in_ready", 32'(bus.in_ready), 1);

    // Counter wrap with CNT_W=2: 1,2,3,0,1
    do_reset();
    exp_cnt = 2'd0;
    for (int w = 0; w < 5; w++) begin
      n = 0;
      while (!bus.out_valid && n < 10) begin
        feed(sample_t'(w + n));
        n++;
      end
      check_eq("wrap_fill_ok", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      exp_cnt = exp_cnt + 2'd1;
      check_eq("wrap_win_cnt", 32'(bus.win_cnt), 32'(exp_cnt));
      $display("pop %0d win_cnt=%0d", w, bus.win_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mode_win_buf.md
MODE_WIN_BUF -- requirements
Module: mode_win_buf

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the emitted-window counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  synchronous window discard; rst has priority.
REQ-005 in_valid  input  1  in_data holds a sample.
REQ-006 in_data  input  4  unsigned sample.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_valid  output  1  i0..i4 hold a complete window for the mode finder.
REQ-009 out_ready  input  1  mode finder consumes the window this cycle.
REQ-010 i0, i1, i2, i3, i4  output  4 each  window, i0 oldest to i4 newest; feed mode_max directly.
REQ-011 win_cnt  output  CNT_W  count of consumed windows.

Function
REQ-012 acc = in_valid & in_ready; pop = out_valid & out_ready; in_ready = !out_valid | out_ready, combinational, with no dependence on in_valid.
REQ-013 On acc, the window shifts: i0<=i1, i1<=i2, i2<=i3, i3<=i4, i4<=in_data. Without acc, i0..i4 hold.
REQ-014 Fill counter cnt ranges 0..5. States: FILL (cnt<5) and FULL (cnt==5). acc in FILL increments cnt.
REQ-015 out_valid rises the cycle after the acc that moves cnt from 4 to 5, giving 5-accept latency from empty.
REQ-016 While out_valid=1 and out_ready=0, i0..i4 and out_valid are stable and in_ready=0.
REQ-017 pop without acc clears out_valid next cycle.
REQ-018 On pop, win_cnt increments by 1 and wraps from 2^CNT_W-1 to 0.
REQ-019 flush clears cnt and out_valid next cycle and leaves win_cnt and i0..i4 unchanged; a same-cycle acc is discarded; a same-cycle pop still counts.
REQ-020 Any in_data value 0..15 is passed through unmodified; there is no arithmetic on samples.

Reset
REQ-021 rst drives cnt=0, out_valid=0, win_cnt=0 and i0..i4=0 on the next edge, overriding acc, pop and flush.
REQ-022 rst mid-window discards partial and pending windows; in_ready reads 1 in the cycle after rst deasserts.

Configuration
REQ-023 Macro MODE_WIN_SLIDE_EN selects the windowing mode.
REQ-024 With MODE_WIN_SLIDE_EN defined (sliding windows):
 - cnt stays 5 after the first fill.
 - Every acc in FULL, including simultaneous pop+acc, sets out_valid next cycle with the shifted window.
REQ-025 Without MODE_WIN_SLIDE_EN (disjoint windows):
 - pop sets cnt to 1 if a simultaneous acc occurs, else to 0.
 - out_valid is set only by the 4->5 transition, so each sample appears in exactly one window.

Structure
REQ-026 Package mode_pkg holds DATA_W=4, WIN_LEN=5 and typedef sample_t (logic [DATA_W-1:0]); the block imports it.
REQ-027 One sub-module, mode_win_ctrl, holds cnt, out_valid and in_ready logic; the data shift register stays in mode_win_buf.

Verification
REQ-028 Verification scenarios (each is stimulus -> required response):
 - Fill: after rst, out_ready=1, accept 3,7,7,1,9 on consecutive cycles -> out_valid=1 one cycle after the 5th accept with i0..i4=3,7,7,1,9; win_cnt=1 after the pop.
 - Backpressure: full window and out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs stable, no sample lost; the next sample is accepted in the cycle out_ready rises.
 - Slide (macro on): after fill 1,2,3,4,5, accept 6 during the pop -> next window 2,3,4,5,6 with out_valid=1 the following cycle.
 - Disjoint (macro off): stream 0..9 with out_ready=1 -> exactly two windows, 0,1,2,3,4 then 5,6,7,8,9.
 - Flush/reset: flush after 3 samples, then 5 samples a..e -> window is a..e. rst asserted with out_valid=1 -> out_valid=0, win_cnt=0 next cycle.
 - Wrap: CNT_W=2, 5 windows consumed -> win_cnt sequence 1,2,3,0,1.
